serializer_nto1: RTL

- Parametrised single-clock successor to the fixed 10:1 display serializer.
- Serializes CHANNELS parallel words of WIDTH bits each into CHANNELS one-bit streams, one bit per i_clk cycle, in fabric logic with no vendor primitives.
- Adds a valid/ready word handshake, selectable bit order, idle-word substitution on underrun, and a word-alignment strobe.
- Feeds TMDS-style links or simulation models where a primitive-based serializer is unavailable.

---
 rtl/serializer_nto1.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serializer_nto1.sv
// N:1 fabric serializer: CHANNELS lanes of WIDTH-bit words, valid/ready word handshake,
// idle-word fill on underrun. Optional clock-pattern words with SERIALIZER_PATTERN_EN.
module serializer_nto1 #(
    parameter int               CHANNELS  = 3,
    parameter int               WIDTH     = 10,
    parameter bit               MSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b1101010100)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_clear_underrun,
`ifdef SERIALIZER_PATTERN_EN
    input  logic                      i_pattern,
`endif
    output logic [CHANNELS-1:0]       o_serial,
    output logic                      o_word_start,
    output logic                      o_underrun
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam int               FIRST_IDX = MSB_FIRST ? WIDTH - 1 : 0;

`ifdef SERIALIZER_PATTERN_EN
    function automatic logic [WIDTH-1:0] clock_pattern();
        logic [WIDTH-1:0] p;
        p = '0;
        for (int n = 0; n < (WIDTH + 1) / 2; n++) begin
            p[MSB_FIRST ? WIDTH - 1 - n : n] = 1'b1;
        end
        return p;
    endfunction

    localparam logic [WIDTH-1:0] PATTERN_WORD = clock_pattern();
`endif

    // The shift register always holds the bits still to be sent, next one at FIRST_IDX.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             running;
    logic             first_bnd;
    logic             boundary;
    logic             pattern_sel;
    logic             load_data;
    logic             set_underrun;
    logic             ready_nxt;
    logic [WIDTH-1:0] sr        [CHANNELS];
    logic [WIDTH-1:0] load_word [CHANNELS];

`ifdef SERIALIZER_PATTERN_EN
    assign pattern_sel = i_pattern;
`else
    assign pattern_sel = 1'b0;
`endif

    always_comb begin
        boundary     = running && (cnt == CNT_LAST);
        load_data    = boundary && o_ready && i_valid && !pattern_sel;
        set_underrun = boundary && !pattern_sel && !load_data && !first_bnd;
        cnt_nxt      = cnt;
        if (boundary) begin
            cnt_nxt = '0;
        end else if (running) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        ready_nxt = (cnt_nxt == CNT_LAST) && !pattern_sel;
        for (int c = 0; c < CHANNELS; c++) begin
            load_word[c] = IDLE_WORD;
            if (load_data) begin
                load_word[c] = i_data[c*WIDTH +: WIDTH];
            end
`ifdef SERIALIZER_PATTERN_EN
            if (pattern_sel) begin
                load_word[c] = PATTERN_WORD;
            end
`endif
        end
    end

    // The first edge after reset release only arms o_ready; the first boundary follows it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt          <= CNT_LAST;
            running      <= 1'b0;
            first_bnd    <= 1'b1;
            o_ready      <= 1'b0;
            o_word_start <= 1'b0;
            o_underrun   <= 1'b0;
            o_serial     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sr[c] <= IDLE_WORD;
            end
        end else begin
            cnt          <= cnt_nxt;
            running      <= 1'b1;
            o_ready      <= ready_nxt;
            o_word_start <= boundary;
            if (boundary) begin
                first_bnd <= 1'b0;
            end
            if (set_underrun) begin
                o_underrun <= 1'b1;
            end else if (i_clear_underrun) begin
                o_underrun <= 1'b0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (boundary) begin
                    o_serial[c] <= load_word[c][FIRST_IDX];
                    sr[c]       <= shift_word(load_word[c]);
                end else if (running) begin
                    o_serial[c] <= sr[c][FIRST_IDX];
                    sr[c]       <= shift_word(sr[c]);
                end else begin
                    o_serial[c] <= 1'b0;
                end
            end
        end
    end

endmodule
